// File: rtl/fm_cmn_dram_02_if.sv
// Request/response bundle for fm_cmn_dram_02: port-A read/write, port-B read, clear control.
// slave = the RAM, master = the block driving it.
interface fm_cmn_dram_02_if #(
    parameter int P_WIDTH = 32,
    parameter int P_RANGE = 2
);
    localparam int P_BE_WIDTH = P_WIDTH / 8;

    logic                  i_clr;
    logic                  o_busy;
    logic                  i_we;
    logic [P_BE_WIDTH-1:0] i_be;
    logic [P_RANGE-1:0]    i_a;
    logic [P_WIDTH-1:0]    i_di;
    logic [P_WIDTH-1:0]    o_spo;
    logic                  i_ren_b;
    logic [P_RANGE-1:0]    i_dpra;
    logic [P_WIDTH-1:0]    o_dpo;
    logic                  o_dpo_valid;

    modport slave (
        input  i_clr, i_we, i_be, i_a, i_di, i_ren_b, i_dpra,
        output o_busy, o_spo, o_dpo, o_dpo_valid
    );

    modport master (
        output i_clr, i_we, i_be, i_a, i_di, i_ren_b, i_dpra,
        input  o_busy, o_spo, o_dpo, o_dpo_valid
    );
endinterface

// File: rtl/fm_cmn_dram_02.sv
// Dual-port distributed RAM with byte enables, port-B collision mode and a self-clearing init sequencer.
// Read latency 1 (+1 with P_OUT_REG); no backpressure, user writes are dropped while o_busy is high.
module fm_cmn_dram_02 #(
    parameter int                 P_WIDTH    = 32,
    parameter int                 P_RANGE    = 2,
    parameter int                 P_DEPTH    = 1 << P_RANGE,
    parameter int                 P_BE_WIDTH = P_WIDTH / 8,
    parameter int                 P_B_MODE   = 0,
    parameter int                 P_OUT_REG  = 0,
    parameter logic [P_WIDTH-1:0] P_CLR_VAL  = '0
) (
    input logic               clk_core,
    input logic               rst_x,
    fm_cmn_dram_02_if.slave   bus
);

    typedef enum logic {ST_CLR, ST_IDLE} state_t;

    localparam logic [P_RANGE-1:0] LAST_IDX = P_RANGE'(P_DEPTH - 1);

    state_t               state_q, state_d;
    logic [P_RANGE-1:0]   cnt_q, cnt_d;
    logic                 busy;

    logic [P_WIDTH-1:0]   ram [P_DEPTH];
    logic                 a_ok, b_ok;
    logic                 wr_eff;
    logic [P_WIDTH-1:0]   rd_a, rd_b, merged;

    logic [P_WIDTH-1:0]   spo1, dpo1;
    logic                 valid1;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            state_q <= ST_CLR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            ST_CLR: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.i_clr) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLR;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_busy = busy;

    // ---------------- storage and read/merge paths ----------------
    // Partial depth leaves a hole in the address space that reads back as the clear value.
    if (P_DEPTH == (1 << P_RANGE)) begin : g_full
        assign a_ok = 1'b1;
        assign b_ok = 1'b1;
    end else begin : g_part
        assign a_ok = (int'(bus.i_a)    < P_DEPTH);
        assign b_ok = (int'(bus.i_dpra) < P_DEPTH);
    end

    assign wr_eff = (state_q == ST_IDLE) && bus.i_we && a_ok;

    always_comb begin
        rd_a = a_ok ? ram[bus.i_a] : P_CLR_VAL;
    end

    always_comb begin
        merged = rd_a;
        for (int n = 0; n < P_BE_WIDTH; n++) begin
            if (bus.i_be[n]) merged[8*n +: 8] = bus.i_di[8*n +: 8];
        end
    end

    always_comb begin
        rd_b = b_ok ? ram[bus.i_dpra] : P_CLR_VAL;
        if ((P_B_MODE != 0) && wr_eff && (bus.i_a == bus.i_dpra)) rd_b = merged;
    end

    // Contents are deliberately not reset; the clear sequencer initialises them.
    always_ff @(posedge clk_core) begin
        if (busy)        ram[cnt_q]   <= P_CLR_VAL;
        else if (wr_eff) ram[bus.i_a] <= merged;
    end

    // ---------------- first pipeline stage ----------------
    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            spo1   <= '0;
            dpo1   <= '0;
            valid1 <= 1'b0;
        end else begin
            spo1   <= wr_eff ? merged : rd_a;
            if (bus.i_ren_b) dpo1 <= rd_b;
            valid1 <= bus.i_ren_b;
        end
    end

    // ---------------- optional output register ----------------
    if (P_OUT_REG != 0) begin : g_oreg
        logic [P_WIDTH-1:0] spo2, dpo2;
        logic               valid2;

        always_ff @(posedge clk_core or negedge rst_x) begin
            if (!rst_x) begin
                spo2   <= '0;
                dpo2   <= '0;
                valid2 <= 1'b0;
            end else begin
                spo2   <= spo1;
                if (valid1) dpo2 <= dpo1;
                valid2 <= valid1;
            end
        end

        assign bus.o_spo       = spo2;
        assign bus.o_dpo       = dpo2;
        assign bus.o_dpo_valid = valid2;
    end else begin : g_direct
        assign bus.o_spo       = spo1;
        assign bus.o_dpo       = dpo1;
        assign bus.o_dpo_valid = valid1;
    end

endmodule

// File: tb/tb_fm_cmn_dram_02.sv
// Directed bench: four RAM variants (read-first, write-first, output-registered, depth 3) on shared stimulus.
// Every comparison goes through chk; expected values are hand-computed constants.
module tb_fm_cmn_dram_02;

    localparam logic [31:0] CLR = 32'hA5A5_0F0F;

    logic        clk_core = 1'b0;
    logic        rst_x    = 1'b0;

    logic        clr   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [1:0]  a     = 2'd0;
    logic [31:0] di    = 32'h0;
    logic        ren_b = 1'b0;
    logic [1:0]  dpra  = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_core = ~clk_core;

    fm_cmn_dram_02_if #(.P_WIDTH(32), .P_RANGE(2)) b0 ();
    fm_cmn_dram_02_if #(.P_WIDTH(32), .P_RANGE(2)) b1 ();
    fm_cmn_dram_02_if #(.P_WIDTH(32), .P_RANGE(2)) b2 ();
    fm_cmn_dram_02_if #(.P_WIDTH(32), .P_RANGE(2)) b3 ();

    always_comb begin
        b0.i_clr = clr; b0.i_we = we; b0.i_be = be; b0.i_a = a; b0.i_di = di; b0.i_ren_b = ren_b; b0.i_dpra = dpra;
    end
    always_comb begin
        b1.i_clr = clr; b1.i_we = we; b1.i_be = be; b1.i_a = a; b1.i_di = di; b1.i_ren_b = ren_b; b1.i_dpra = dpra;
    end
    always_comb begin
        b2.i_clr = clr; b2.i_we = we; b2.i_be = be; b2.i_a = a; b2.i_di = di; b2.i_ren_b = ren_b; b2.i_dpra = dpra;
    end
    always_comb begin
        b3.i_clr = clr; b3.i_we = we; b3.i_be = be; b3.i_a = a; b3.i_di = di; b3.i_ren_b = ren_b; b3.i_dpra = dpra;
    end

    fm_cmn_dram_02 #(.P_B_MODE(0), .P_OUT_REG(0), .P_CLR_VAL(CLR)) u0 (.clk_core(clk_core), .rst_x(rst_x), .bus(b0));
    fm_cmn_dram_02 #(.P_B_MODE(1), .P_OUT_REG(0), .P_CLR_VAL(CLR)) u1 (.clk_core(clk_core), .rst_x(rst_x), .bus(b1));
    fm_cmn_dram_02 #(.P_B_MODE(0), .P_OUT_REG(1), .P_CLR_VAL(CLR)) u2 (.clk_core(clk_core), .rst_x(rst_x), .bus(b2));
    fm_cmn_dram_02 #(.P_DEPTH(3),  .P_CLR_VAL(CLR))                u3 (.clk_core(clk_core), .rst_x(rst_x), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    // Samples o_busy for a fixed window and reports how many cycles it was high.
    task automatic busy_cnt(output int c0, output int c2, output int c3);
        c0 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < 8; i++) begin
            if (b0.o_busy) c0++;
            if (b2.o_busy) c2++;
            if (b3.o_busy) c3++;
            tick();
        end
    endtask

    initial begin
        int c0, c2, c3;

        // T1: reset state, clear length, all entries read back as clear value
        #3;
        chk("rst_spo",   b0.o_spo, 32'h0);
        chk("rst_dpo",   b0.o_dpo, 32'h0);
        chk("rst_valid", {31'h0, b0.o_dpo_valid}, 32'h0);
        chk("rst_busy",  {31'h0, b0.o_busy}, 32'h1);
        tick();
        rst_x = 1'b1;
        busy_cnt(c0, c2, c3);
        chk("t1_busy_len_d4",  c0, 4);
        chk("t1_busy_len_reg", c2, 4);
        chk("t1_busy_len_d3",  c3, 3);

        for (int i = 0; i <= 4; i++) begin
            ren_b = (i < 4);
            dpra  = 2'(i);
            tick();
            if (i < 4) begin
                chk("t1_dpo",       b0.o_dpo, CLR);
                chk("t1_valid",     {31'h0, b0.o_dpo_valid}, 32'h1);
                chk("t1_dpo_d3",    b3.o_dpo, CLR);
            end else begin
                chk("t1_valid_off", {31'h0, b0.o_dpo_valid}, 32'h0);
            end
            if (i > 0) begin
                chk("t1_reg_dpo",   b2.o_dpo, CLR);
                chk("t1_reg_valid", {31'h0, b2.o_dpo_valid}, 32'h1);
            end
        end

        // T2: byte-enable merge on back-to-back writes
        we = 1'b1; be = 4'hF; a = 2'd1; di = 32'h1122_3344;
        tick();
        chk("t2_spo_w1", b0.o_spo, 32'h1122_3344);
        be = 4'b0101; di = 32'hAABB_CCDD;
        tick();
        chk("t2_spo_w2",     b0.o_spo, 32'h11BB_33DD);
        chk("t2_reg_spo_w1", b2.o_spo, 32'h1122_3344);
        we = 1'b0; ren_b = 1'b1; dpra = 2'd1;
        tick();
        chk("t2_dpo",        b0.o_dpo, 32'h11BB_33DD);
        chk("t2_reg_spo_w2", b2.o_spo, 32'h11BB_33DD);
        ren_b = 1'b0;
        tick();
        chk("t2_dpo_hold",   b0.o_dpo, 32'h11BB_33DD);
        chk("t2_valid_off",  {31'h0, b0.o_dpo_valid}, 32'h0);
        chk("t2_reg_dpo",    b2.o_dpo, 32'h11BB_33DD);
        chk("t2_reg_valid",  {31'h0, b2.o_dpo_valid}, 32'h1);

        // T3: same-address collision, read-first vs write-first
        we = 1'b1; be = 4'hF; a = 2'd2; di = 32'h5A5A_5A5A; ren_b = 1'b1; dpra = 2'd2;
        tick();
        chk("t3_rf_old", b0.o_dpo, CLR);
        chk("t3_wf_new", b1.o_dpo, 32'h5A5A_5A5A);
        we = 1'b0;
        tick();
        chk("t3_rf_next", b0.o_dpo, 32'h5A5A_5A5A);
        ren_b = 1'b0;

        // T4: clear lockout and re-trigger while busy
        clr = 1'b1;
        tick();
        chk("t4_busy_start", {31'h0, b0.o_busy}, 32'h1);
        tick();
        clr = 1'b0;
        we = 1'b1; be = 4'hF; a = 2'd0; di = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        chk("t4_spo_locked", b0.o_spo, CLR);
        busy_cnt(c0, c2, c3);
        chk("t4_busy_rest_d4", c0, 2);
        chk("t4_busy_rest_d3", c3, 1);
        ren_b = 1'b1; dpra = 2'd0;
        tick();
        ren_b = 1'b0;
        chk("t4_dpo_a0", b0.o_dpo, CLR);
        chk("t4_spo_a0", b0.o_spo, CLR);
        chk("t4_dpo_a0_wf", b1.o_dpo, CLR);

        // T5: output register latency; depth-3 hole drops writes
        we = 1'b1; be = 4'hF; a = 2'd3; di = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; ren_b = 1'b1; dpra = 2'd3;
        tick();
        ren_b = 1'b0;
        chk("t5_dpo_lat1",     b0.o_dpo, 32'hDEAD_BEEF);
        chk("t5_d3_hole",      b3.o_dpo, CLR);
        chk("t5_reg_valid_1",  {31'h0, b2.o_dpo_valid}, 32'h0);
        tick();
        chk("t5_reg_dpo_2",    b2.o_dpo, 32'hDEAD_BEEF);
        chk("t5_reg_valid_2",  {31'h0, b2.o_dpo_valid}, 32'h1);
        tick();
        chk("t5_reg_dpo_hold", b2.o_dpo, 32'hDEAD_BEEF);
        chk("t5_reg_valid_0",  {31'h0, b2.o_dpo_valid}, 32'h0);
        chk("t5_spo_a3",       b0.o_spo, 32'hDEAD_BEEF);

        // T6: reset in the middle of a clear restarts it from entry 0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        rst_x = 1'b0;
        #1;
        chk("t6_rst_spo",     b0.o_spo, 32'h0);
        chk("t6_rst_dpo",     b0.o_dpo, 32'h0);
        chk("t6_rst_reg_spo", b2.o_spo, 32'h0);
        chk("t6_rst_reg_dpo", b2.o_dpo, 32'h0);
        chk("t6_rst_busy",    {31'h0, b0.o_busy}, 32'h1);
        tick();
        rst_x = 1'b1;
        busy_cnt(c0, c2, c3);
        chk("t6_busy_len_d4", c0, 4);
        chk("t6_busy_len_d3", c3, 3);
        ren_b = 1'b1; dpra = 2'd3;
        tick();
        ren_b = 1'b0;
        chk("t6_dpo_a3", b0.o_dpo, CLR);
        chk("t6_spo_a3", b0.o_spo, CLR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
